// File: rtl/game_pkg.sv
// Shared types and constants for the ChickenCHACHACHA game-control logic.
package game_pkg;

   localparam int unsigned MAX_PLAYERS = 4;
   localparam int unsigned PLAYER_W    = $clog2(MAX_PLAYERS);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWaitCard = 3'd1,
      StCheck    = 3'd2,
      StMove     = 3'd3,
      StWinChk   = 3'd4,
      StNext     = 3'd5,
      StOver     = 3'd6
   } state_e;

   // N == 0 still means two players; an index already past the limit wraps to 0.
   function automatic logic [PLAYER_W-1:0] next_player(input logic [PLAYER_W-1:0] cur,
                                                       input logic [PLAYER_W-1:0] n);
      logic [PLAYER_W-1:0] neff;
      neff = (n == '0) ? PLAYER_W'(1) : n;
      return (cur >= neff) ? '0 : cur + PLAYER_W'(1);
   endfunction

endpackage

// File: rtl/turn_timer.sv
// Turn timeout counter: clear has priority over enable; tc flags the last allowed cycle.
module turn_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned TW             = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [TW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + TW'(1);
      end
   end

   assign tc = (count_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/turn_ctrl_fsm.sv
// Turn sequencer for the board game: card pick, match check, chicken move, win check.
module turn_ctrl_fsm
   import game_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned TW             = 26
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          N,
   input  logic                card_valid,
   input  logic                same_valid,
   input  logic                same_result,
   input  logic                win_valid,
   input  logic                win,
   output logic                check_req,
   output logic                move_en,
   output logic                statecombo_next_turn,
   output logic [PLAYER_W-1:0] cur_player,
   output logic                game_over,
   output logic [PLAYER_W-1:0] winner
);

   state_e              state_q, state_d;
   logic                check_req_q, check_req_d;
   logic                move_en_q, move_en_d;
   logic                next_turn_q, next_turn_d;
   logic [PLAYER_W-1:0] cur_player_q, cur_player_d;
   logic                game_over_q, game_over_d;
   logic [PLAYER_W-1:0] winner_q, winner_d;
   logic                timer_clear, timer_en, timer_tc;

   // Any cycle that does not stay in WAIT_CARD restarts the timeout window.
   assign timer_en    = (state_q == StWaitCard);
   assign timer_clear = !((state_q == StWaitCard) && (state_d == StWaitCard));

   turn_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TW            (TW)
   ) u_turn_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (timer_clear),
      .enable(timer_en),
      .tc    (timer_tc)
   );

   always_comb begin
      state_d      = state_q;
      check_req_d  = 1'b0;
      move_en_d    = 1'b0;
      next_turn_d  = 1'b0;
      cur_player_d = cur_player_q;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d      = StWaitCard;
               cur_player_d = '0;
            end
         end
         StWaitCard: begin
            // A card arriving on the timeout cycle still counts.
            if (card_valid) begin
               state_d     = StCheck;
               check_req_d = 1'b1;
            end else if (timer_tc) begin
               state_d     = StNext;
               next_turn_d = 1'b1;
            end
         end
         StCheck: begin
            if (same_valid) begin
               if (same_result) begin
                  state_d   = StMove;
                  move_en_d = 1'b1;
               end else begin
                  state_d     = StNext;
                  next_turn_d = 1'b1;
               end
            end
         end
         StMove: begin
            state_d = StWinChk;
         end
         StWinChk: begin
            if (win_valid) begin
               if (win) begin
                  state_d     = StOver;
                  winner_d    = cur_player_q;
                  game_over_d = 1'b1;
               end else begin
                  state_d = StWaitCard;
               end
            end
         end
         StNext: begin
            state_d      = StWaitCard;
            cur_player_d = next_player(cur_player_q, N);
         end
         StOver: begin
            if (start) begin
               state_d      = StWaitCard;
               game_over_d  = 1'b0;
               cur_player_d = '0;
            end
         end
         default: begin
            state_d     = StIdle;
            game_over_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         check_req_q  <= 1'b0;
         move_en_q    <= 1'b0;
         next_turn_q  <= 1'b0;
         cur_player_q <= '0;
         game_over_q  <= 1'b0;
         winner_q     <= '0;
      end else begin
         state_q      <= state_d;
         check_req_q  <= check_req_d;
         move_en_q    <= move_en_d;
         next_turn_q  <= next_turn_d;
         cur_player_q <= cur_player_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
      end
   end

   assign check_req            = check_req_q;
   assign move_en              = move_en_q;
   assign statecombo_next_turn = next_turn_q;
   assign cur_player           = cur_player_q;
   assign game_over            = game_over_q;
   assign winner               = winner_q;

endmodule

// File: tb/tb_turn_ctrl_fsm.sv
// Scenario bench for turn_ctrl_fsm: pulses are matched against a scoreboard queue.
module tb_turn_ctrl_fsm;

   localparam logic [2:0] P_CHK = 3'b001;
   localparam logic [2:0] P_MOV = 3'b010;
   localparam logic [2:0] P_NXT = 3'b100;

   typedef struct packed {
      logic [2:0] pulses;
      logic [1:0] player;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, card_valid, same_valid, same_result, win_valid, win;
   logic [1:0] N;
   logic       check_req, move_en, statecombo_next_turn, game_over;
   logic [1:0] cur_player, winner;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   turn_ctrl_fsm #(
      .TIMEOUT_CYCLES(8),
      .TW            (4)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .N                   (N),
      .card_valid          (card_valid),
      .same_valid          (same_valid),
      .same_result         (same_result),
      .win_valid           (win_valid),
      .win                 (win),
      .check_req           (check_req),
      .move_en             (move_en),
      .statecombo_next_turn(statecombo_next_turn),
      .cur_player          (cur_player),
      .game_over           (game_over),
      .winner              (winner)
   );

   // Every pulse seen must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [2:0] obs;
      exp_t       e;
      obs = {statecombo_next_turn, move_en, check_req};
      if (rst_n === 1'b1 && obs !== 3'b000) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got pulses=%b player=%0d, required none", obs,
                     cur_player);
         end else begin
            e = sb.pop_front();
            if (obs !== e.pulses || cur_player !== e.player) begin
               bad++;
               $display("FAIL pulse: got pulses=%b player=%0d, required pulses=%b player=%0d",
                        obs, cur_player, e.pulses, e.player);
            end
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_card(input logic [1:0] p);
      sb.push_back('{pulses: P_CHK, player: p});
      card_valid = 1'b1;
      @(negedge clk);
      card_valid = 1'b0;
   endtask

   // Returns at the first WAIT_CARD cycle (mismatch) or the first WIN_CHK cycle (match).
   task automatic do_same(input logic res, input logic [1:0] p);
      sb.push_back('{pulses: (res ? P_MOV : P_NXT), player: p});
      same_valid  = 1'b1;
      same_result = res;
      @(negedge clk);
      same_valid  = 1'b0;
      same_result = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_win(input logic w);
      win_valid = 1'b1;
      win       = w;
      @(negedge clk);
      win_valid = 1'b0;
      win       = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({check_req, move_en, statecombo_next_turn, cur_player, game_over, winner} !== 9'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b, required all zero",
                  {check_req, move_en, statecombo_next_turn, cur_player, game_over, winner});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({check_req, move_en, statecombo_next_turn, game_over} !== 4'd0) begin
         bad++;
         $display("FAIL idle_quiet: got %b, required 0000",
                  {check_req, move_en, statecombo_next_turn, game_over});
      end
   endtask

   task automatic test_mismatch();
      N = 2'd2;
      do_start();
      total++;
      if (cur_player !== 2'd0 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL start: got player=%0d over=%b, required player=0 over=0", cur_player,
                  game_over);
      end
      do_card(2'd0);
      do_same(1'b0, 2'd0);
      total++;
      if (cur_player !== 2'd1) begin
         bad++;
         $display("FAIL mismatch_pass: got player=%0d, required 1", cur_player);
      end
   endtask

   task automatic test_rotation();
      logic [1:0] n_tab[7]   = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
      logic [1:0] p_tab[7]   = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
      logic [1:0] exp_tab[7] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
      for (int i = 0; i < 7; i++) begin
         N = n_tab[i];
         do_card(p_tab[i]);
         do_same(1'b0, p_tab[i]);
         total++;
         if (cur_player !== exp_tab[i]) begin
            bad++;
            $display("FAIL rotation[%0d]: got player=%0d, required %0d", i, cur_player,
                     exp_tab[i]);
         end
      end
      N = 2'd2;
   endtask

   task automatic test_match();
      do_card(2'd0);
      do_same(1'b1, 2'd0);
      do_win(1'b0);
      total++;
      if (cur_player !== 2'd0 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL match_no_win: got player=%0d over=%b, required player=0 over=0",
                  cur_player, game_over);
      end
      do_card(2'd0);
      do_same(1'b0, 2'd0);
      do_start();
      total++;
      if (cur_player !== 2'd1) begin
         bad++;
         $display("FAIL start_ignored: got player=%0d, required 1", cur_player);
      end
      do_card(2'd1);
      do_same(1'b0, 2'd1);
   endtask

   task automatic test_timeout();
      sb.push_back('{pulses: P_NXT, player: 2'd2});
      repeat (7) @(negedge clk);
      total++;
      if (statecombo_next_turn !== 1'b0) begin
         bad++;
         $display("FAIL timeout_early: got next_turn=%b, required 0", statecombo_next_turn);
      end
      @(negedge clk);
      total++;
      if (statecombo_next_turn !== 1'b1) begin
         bad++;
         $display("FAIL timeout_pass: got next_turn=%b, required 1", statecombo_next_turn);
      end
      @(negedge clk);
      total++;
      if (cur_player !== 2'd0) begin
         bad++;
         $display("FAIL timeout_player: got player=%0d, required 0", cur_player);
      end
      repeat (7) @(negedge clk);
      do_card(2'd0);
      total++;
      if (check_req !== 1'b1 || statecombo_next_turn !== 1'b0) begin
         bad++;
         $display("FAIL card_at_timeout: got check=%b next=%b, required check=1 next=0",
                  check_req, statecombo_next_turn);
      end
      do_same(1'b1, 2'd0);
      do_win(1'b0);
      total++;
      if (cur_player !== 2'd0) begin
         bad++;
         $display("FAIL late_card_player: got player=%0d, required 0", cur_player);
      end
   endtask

   task automatic test_win();
      do_card(2'd0);
      do_same(1'b0, 2'd0);
      do_card(2'd1);
      do_same(1'b0, 2'd1);
      do_card(2'd2);
      do_same(1'b1, 2'd2);
      do_win(1'b1);
      total++;
      if (game_over !== 1'b1 || winner !== 2'd2) begin
         bad++;
         $display("FAIL win: got over=%b winner=%0d, required over=1 winner=2", game_over, winner);
      end
      card_valid = 1'b1;
      @(negedge clk);
      card_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (game_over !== 1'b1 || winner !== 2'd2) begin
         bad++;
         $display("FAIL over_hold: got over=%b winner=%0d, required over=1 winner=2", game_over,
                  winner);
      end
      do_start();
      total++;
      if (game_over !== 1'b0 || cur_player !== 2'd0) begin
         bad++;
         $display("FAIL restart: got over=%b player=%0d, required over=0 player=0", game_over,
                  cur_player);
      end
   endtask

   task automatic test_reset_mid();
      do_card(2'd0);
      do_same(1'b0, 2'd0);
      do_card(2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({check_req, move_en, statecombo_next_turn, cur_player, game_over, winner} !== 9'd0) begin
         bad++;
         $display("FAIL async_reset: got %b, required all zero",
                  {check_req, move_en, statecombo_next_turn, cur_player, game_over, winner});
      end
      @(negedge clk);
      rst_n       = 1'b1;
      same_valid  = 1'b1;
      same_result = 1'b1;
      @(negedge clk);
      same_valid  = 1'b0;
      same_result = 1'b0;
      card_valid  = 1'b1;
      @(negedge clk);
      card_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (cur_player !== 2'd0 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: got player=%0d over=%b, required 0/0", cur_player,
                  game_over);
      end
      do_start();
      do_card(2'd0);
      do_same(1'b0, 2'd0);
      total++;
      if (cur_player !== 2'd1) begin
         bad++;
         $display("FAIL post_reset_game: got player=%0d, required 1", cur_player);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      N           = 2'd0;
      card_valid  = 1'b0;
      same_valid  = 1'b0;
      same_result = 1'b0;
      win_valid   = 1'b0;
      win         = 1'b0;
      test_reset();
      test_mismatch();
      test_rotation();
      test_match();
      test_timeout();
      test_win();
      test_reset_mid();
      repeat (2) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL missing_pulses: got %0d outstanding, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
